// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and constants for the PC sequencer.
//   state_t       sequencer FSM states
//   PC_INC        sequential fetch stride in bytes
//   DEF_RESET_PC  default PC presented while idle / after reset
//   WDOG_W        width of the ack-timeout counter and its limit
//   align_word()  clears the byte-offset bits of an address
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_HOLD     = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  localparam logic [31:0] PC_INC       = 32'd4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int          WDOG_W       = 8;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: instruction-memory fetch handshake.
//   imem_req  fetch request from the sequencer (address is the current PC)
//   imem_ack  memory returns instruction data this cycle
// Modports: master = sequencer side, slave = memory side.
interface pc_sequencer_if;
  logic imem_req;
  logic imem_ack;

  modport master (output imem_req, input imem_ack);
  modport slave  (input imem_req, output imem_ack);
endinterface

// File: rtl/ack_watchdog.sv
// ack_watchdog: counts wait cycles of an outstanding fetch.
//   clk_i, rst_i  clock, synchronous active-high reset
//   i_en          count one more cycle without ack
//   i_clr         restart from zero (has priority over i_en)
//   i_limit       terminal count
//   o_expired     counter has reached i_limit
module ack_watchdog
  import pc_seq_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic [WDOG_W-1:0] i_limit,
  output logic              o_expired
);

  logic [WDOG_W-1:0] r_count;

  // Saturates at the limit so a late clear never sees a wrapped value.
  always_ff @(posedge clk_i) begin
    if (rst_i)                       r_count <= '0;
    else if (i_clr)                  r_count <= '0;
    else if (i_en && !o_expired)     r_count <= r_count + WDOG_W'(1);
  end

  assign o_expired = (r_count == i_limit);

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction-fetch control; drives the PC register load
// strobe, IF/ID valid/flush and the memory request, with a sticky ack timeout.
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i             run enable
//   stall_i             decode hazard stall
//   branch_i            taken branch/jump resolved this cycle
//   branch_target_i     redirect address (word-aligned internally)
//   pc_i                current PC register value
//   imem                fetch handshake (master)
//   pc_write_o          PC load strobe
//   pc_next_o           value to load into the PC
//   inst_valid_o        latch returned instruction into IF/ID
//   flush_o             squash IF/ID
//   err_o               sticky fetch timeout
//
// state    | meaning
// IDLE     | no request; waiting for start_i (blocked once err_o is set)
// FETCH    | request outstanding for pc_i
// HOLD     | instruction delivered, PC frozen by stall_i
// REDIRECT | request outstanding whose data is discarded; target latched
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
  parameter int          ACK_TIMEOUT = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  stall_i,
  input  logic                  branch_i,
  input  logic [31:0]           branch_target_i,
  input  logic [31:0]           pc_i,
  pc_sequencer_if.master        imem,
  output logic                  pc_write_o,
  output logic [31:0]           pc_next_o,
  output logic                  inst_valid_o,
  output logic                  flush_o,
  output logic                  err_o
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_target;
  logic        r_err;
  logic [31:0] w_target;
  logic        w_busy;
  logic        w_expired;
  logic        w_timeout;
  logic        w_latch_tgt;

  assign w_target  = align_word(branch_target_i);
  assign w_busy    = (r_state == ST_FETCH) || (r_state == ST_REDIRECT);
  assign w_timeout = w_busy && w_expired;

  ack_watchdog u_wdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_en      (w_busy && !imem.imem_ack),
    .i_clr     (!w_busy || imem.imem_ack),
    .i_limit   (WDOG_W'(ACK_TIMEOUT)),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_target <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_latch_tgt) r_target <= w_target;
      if (w_timeout)   r_err    <= 1'b1;
    end
  end

  // Priority everywhere: branch > stall > sequential.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:
        if (start_i && !r_err) w_state_nxt = ST_FETCH;
      ST_FETCH:
        if (w_timeout)                  w_state_nxt = ST_IDLE;
        else if (imem.imem_ack) begin
          if (branch_i)                 w_state_nxt = ST_FETCH;
          else if (stall_i)             w_state_nxt = ST_HOLD;
          else                          w_state_nxt = start_i ? ST_FETCH : ST_IDLE;
        end else if (branch_i)          w_state_nxt = ST_REDIRECT;
      ST_REDIRECT:
        if (w_timeout)                  w_state_nxt = ST_IDLE;
        else if (imem.imem_ack)         w_state_nxt = ST_FETCH;
      ST_HOLD:
        if (branch_i)                   w_state_nxt = ST_FETCH;
        else if (!stall_i)              w_state_nxt = start_i ? ST_FETCH : ST_IDLE;
      default:                          w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    imem.imem_req = 1'b0;
    pc_write_o    = 1'b0;
    pc_next_o     = pc_i;
    inst_valid_o  = 1'b0;
    flush_o       = 1'b0;
    err_o         = r_err;
    w_latch_tgt   = 1'b0;
    unique case (r_state)
      ST_IDLE:
        pc_next_o = RESET_PC;
      ST_FETCH:
        if (w_timeout) begin
          err_o = 1'b1;
        end else begin
          imem.imem_req = 1'b1;
          if (imem.imem_ack) begin
            if (branch_i) begin
              flush_o    = 1'b1;
              pc_write_o = 1'b1;
              pc_next_o  = w_target;
            end else if (stall_i) begin
              inst_valid_o = 1'b1;
            end else begin
              inst_valid_o = 1'b1;
              pc_write_o   = 1'b1;
              pc_next_o    = pc_i + PC_INC;
            end
          end else if (branch_i) begin
            flush_o     = 1'b1;
            w_latch_tgt = 1'b1;
          end
        end
      ST_REDIRECT:
        if (w_timeout) begin
          err_o = 1'b1;
        end else begin
          imem.imem_req = 1'b1;
          if (branch_i) begin
            flush_o     = 1'b1;
            w_latch_tgt = 1'b1;
          end
          // A branch arriving with the ack is newer than the latched target.
          if (imem.imem_ack) begin
            pc_write_o = 1'b1;
            pc_next_o  = branch_i ? w_target : r_target;
          end
        end
      ST_HOLD:
        if (branch_i) begin
          flush_o    = 1'b1;
          pc_write_o = 1'b1;
          pc_next_o  = w_target;
        end else if (!stall_i) begin
          pc_write_o = 1'b1;
          pc_next_o  = pc_i + PC_INC;
        end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int          TO  = 15;
  localparam logic [31:0] RPC = DEF_RESET_PC;

  logic        clk = 1'b0;
  logic        rst, start, stall, branch, ack;
  logic [31:0] tgt, pc;
  logic        pc_write, inst_valid, flush, err;
  logic [31:0] pc_next;

  int errors = 0;
  int checks = 0;

  pc_sequencer_if imem_if ();
  assign imem_if.imem_ack = ack;

  pc_sequencer #(.RESET_PC(RPC), .ACK_TIMEOUT(TO)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .stall_i         (stall),
    .branch_i        (branch),
    .branch_target_i (tgt),
    .pc_i            (pc),
    .imem            (imem_if),
    .pc_write_o      (pc_write),
    .pc_next_o       (pc_next),
    .inst_valid_o    (inst_valid),
    .flush_o         (flush),
    .err_o           (err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string pfx, input bit req, input bit wr, input logic [31:0] nxt,
                         input bit val, input bit fl, input bit er);
    chk({pfx, "_req"},   {31'd0, imem_if.imem_req}, {31'd0, req});
    chk({pfx, "_write"}, {31'd0, pc_write},         {31'd0, wr});
    chk({pfx, "_next"},  pc_next,                   nxt);
    chk({pfx, "_valid"}, {31'd0, inst_valid},       {31'd0, val});
    chk({pfx, "_flush"}, {31'd0, flush},            {31'd0, fl});
    chk({pfx, "_err"},   {31'd0, err},              {31'd0, er});
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          c;
    bit          rst, start, stall, branch, ack;
    logic [31:0] tgt, pc;
    bit          req, wr;
    logic [31:0] nxt;
    bit          val, fl, er;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit c, bit r, bit s, bit sl, bit b, bit a, logic [31:0] t,
                              logic [31:0] p, bit rq, bit w, logic [31:0] n, bit v, bit f, bit e);
    vec_t x;
    x.c = c; x.rst = r; x.start = s; x.stall = sl; x.branch = b; x.ack = a;
    x.tgt = t; x.pc = p; x.req = rq; x.wr = w; x.nxt = n; x.val = v; x.fl = f; x.er = e;
    return x;
  endfunction

  task automatic drive(input bit r, input bit s, input bit sl, input bit b, input bit a,
                       input logic [31:0] t, input logic [31:0] p);
    rst = r; start = s; stall = sl; branch = b; ack = a; tgt = t; pc = p;
  endtask

  // ---------------- behavioural reference model ----------------
  // Flags describe what the fetch unit is doing, not how the RTL encodes it.
  bit          m_run, m_redir, m_hold, m_err;
  int          m_wait;
  logic [31:0] m_tgt;
  bit          n_run, n_redir, n_hold, n_err;
  int          n_wait;
  logic [31:0] n_tgt;
  bit          e_req, e_wr, e_val, e_fl, e_err;
  logic [31:0] e_next;

  task automatic model_eval();
    logic [31:0] t;
    bit busy, expired;
    t       = tgt & 32'hFFFF_FFFC;
    busy    = m_run || m_redir;
    expired = busy && (m_wait >= TO);
    e_req = 0; e_wr = 0; e_val = 0; e_fl = 0; e_err = m_err; e_next = pc;
    n_run = m_run; n_redir = m_redir; n_hold = m_hold; n_err = m_err; n_tgt = m_tgt;
    if (!busy && !m_hold) begin
      e_next = RPC;
      if (start && !m_err) n_run = 1;
    end else if (expired) begin
      e_err = 1; n_err = 1; n_run = 0; n_redir = 0;
    end else if (m_run) begin
      e_req = 1;
      if (ack) begin
        if (branch) begin e_fl = 1; e_wr = 1; e_next = t; end
        else if (stall) begin e_val = 1; n_run = 0; n_hold = 1; end
        else begin e_val = 1; e_wr = 1; e_next = pc + 32'd4; n_run = start; end
      end else if (branch) begin
        e_fl = 1; n_tgt = t; n_run = 0; n_redir = 1;
      end
    end else if (m_redir) begin
      e_req = 1;
      if (branch) begin e_fl = 1; n_tgt = t; end
      if (ack) begin e_wr = 1; e_next = branch ? t : m_tgt; n_redir = 0; n_run = 1; end
    end else begin
      if (branch) begin e_wr = 1; e_fl = 1; e_next = t; n_hold = 0; n_run = 1; end
      else if (!stall) begin e_wr = 1; e_next = pc + 32'd4; n_hold = 0; n_run = start; end
    end
    n_wait = (busy && !ack && !expired && (n_run || n_redir)) ? m_wait + 1 : 0;
    if (rst) begin
      n_run = 0; n_redir = 0; n_hold = 0; n_err = 0; n_wait = 0; n_tgt = '0;
    end
  endtask

  task automatic model_commit();
    m_run = n_run; m_redir = n_redir; m_hold = n_hold; m_err = n_err;
    m_wait = n_wait; m_tgt = n_tgt;
  endtask

  initial begin
    int ack_pct;
    drive(1, 0, 0, 0, 0, '0, '0);

    // reset, sequential run 0,4,8,C
    vt.push_back(mk(0, 1,0,0,0,0, 32'h0,   32'h0,        0,0,32'h0,  0,0,0));
    vt.push_back(mk(1, 1,0,0,0,0, 32'h0,   32'h55,       0,0,RPC,    0,0,0));
    vt.push_back(mk(1, 0,1,0,0,0, 32'h0,   32'h55,       0,0,RPC,    0,0,0));
    vt.push_back(mk(1, 0,1,0,0,1, 32'h0,   32'h0,        1,1,32'h4,  1,0,0));
    vt.push_back(mk(1, 0,1,0,0,1, 32'h0,   32'h4,        1,1,32'h8,  1,0,0));
    vt.push_back(mk(1, 0,1,0,0,1, 32'h0,   32'h8,        1,1,32'hC,  1,0,0));
    vt.push_back(mk(1, 0,1,0,0,1, 32'h0,   32'hC,        1,1,32'h10, 1,0,0));
    // reset during a fetch with no ack
    vt.push_back(mk(1, 1,1,0,0,0, 32'h0,   32'h10,       1,0,32'h10, 0,0,0));
    vt.push_back(mk(1, 0,1,0,0,0, 32'h0,   32'h10,       0,0,RPC,    0,0,0));
    vt.push_back(mk(1, 0,1,0,0,1, 32'h0,   32'h0,        1,1,32'h4,  1,0,0));
    vt.push_back(mk(1, 0,1,0,0,1, 32'h0,   32'h4,        1,1,32'h8,  1,0,0));
    // ack at 8 with a 3-cycle stall, then release to C
    vt.push_back(mk(1, 0,1,1,0,1, 32'h0,   32'h8,        1,0,32'h8,  1,0,0));
    vt.push_back(mk(1, 0,1,1,0,0, 32'h0,   32'h8,        0,0,32'h8,  0,0,0));
    vt.push_back(mk(1, 0,1,1,0,1, 32'h0,   32'h8,        0,0,32'h8,  0,0,0));
    vt.push_back(mk(1, 0,1,0,0,0, 32'h0,   32'h8,        0,1,32'hC,  0,0,0));
    // branch to 40 two cycles before the ack
    vt.push_back(mk(1, 0,1,0,1,0, 32'h40,  32'hC,        1,0,32'hC,  0,1,0));
    vt.push_back(mk(1, 0,1,0,0,0, 32'h0,   32'hC,        1,0,32'hC,  0,0,0));
    vt.push_back(mk(1, 0,1,0,0,1, 32'h0,   32'hC,        1,1,32'h40, 0,0,0));
    // branch + stall at ack, unaligned target
    vt.push_back(mk(1, 0,1,1,1,1, 32'h103, 32'h40,       1,1,32'h100,0,1,0));
    vt.push_back(mk(1, 0,1,0,0,1, 32'h0,   32'h100,      1,1,32'h104,1,0,0));
    // wrap, then reset during the following fetch
    vt.push_back(mk(1, 0,1,0,0,1, 32'h0,   32'hFFFF_FFFC,1,1,32'h0,  1,0,0));
    vt.push_back(mk(1, 1,1,0,0,0, 32'h0,   32'h0,        1,0,32'h0,  0,0,0));
    vt.push_back(mk(1, 0,0,1,1,1, 32'h200, 32'h8,        0,0,RPC,    0,0,0));

    foreach (vt[i]) begin
      drive(vt[i].rst, vt[i].start, vt[i].stall, vt[i].branch, vt[i].ack, vt[i].tgt, vt[i].pc);
      @(negedge clk);
      if (vt[i].c)
        chk_all($sformatf("vec%0d", i), vt[i].req, vt[i].wr, vt[i].nxt, vt[i].val, vt[i].fl, vt[i].er);
      @(posedge clk); #1;
    end

    // ack timeout: 15 unanswered cycles, then sticky error
    drive(1, 0, 0, 0, 0, '0, 32'h20);
    @(posedge clk); #1;
    drive(0, 1, 0, 0, 0, '0, 32'h20);
    @(posedge clk); #1;
    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      chk($sformatf("to_wait%0d_req", k), {31'd0, imem_if.imem_req}, 32'd1);
      chk($sformatf("to_wait%0d_err", k), {31'd0, err}, 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("to_expire_req",   {31'd0, imem_if.imem_req}, 32'd0);
    chk("to_expire_err",   {31'd0, err},              32'd1);
    chk("to_expire_write", {31'd0, pc_write},         32'd0);
    @(posedge clk); #1;
    ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_all($sformatf("to_idle%0d", k), 0, 0, RPC, 0, 0, 1);
      @(posedge clk); #1;
    end
    drive(1, 0, 0, 0, 0, '0, 32'h20);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, '0, 32'h20);
    @(negedge clk);
    chk("to_reset_err", {31'd0, err}, 32'd0);
    @(posedge clk); #1;

    // randomized run against the reference model
    drive(1, 0, 0, 0, 0, '0, RPC);
    @(posedge clk); #1;
    m_run = 0; m_redir = 0; m_hold = 0; m_err = 0; m_wait = 0; m_tgt = '0;
    ack_pct = 60;
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) ack_pct = ((n / 250) % 2 == 1) ? 4 : 60;
      rst    = ($urandom_range(0, 99) == 0);
      start  = ($urandom_range(0, 9) != 0);
      stall  = ($urandom_range(0, 3) == 0);
      branch = ($urandom_range(0, 6) == 0);
      ack    = ($urandom_range(0, 99) < ack_pct);
      tgt    = $urandom;
      if ($urandom_range(0, 15) == 0) pc = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFC : $urandom;
      model_eval();
      @(negedge clk);
      chk_all($sformatf("rnd%0d", n), e_req, e_wr, e_next, e_val, e_fl, e_err);
      @(posedge clk); #1;
      model_commit();
      if (e_wr && !rst) pc = e_next;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: value driven on pc_next_o while idle and after reset.
REQ-002 Parameter ACK_TIMEOUT, default 15: maximum wait cycles for imem_ack_i before the fetch is aborted.
REQ-003 clk_i  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 start_i  input  1  run enable; high lets fetching begin or continue.
REQ-006 stall_i  input  1  hazard stall from decode; freezes the PC.
REQ-007 branch_i  input  1  taken branch or jump resolved this cycle.
REQ-008 branch_target_i  input  32  redirect address; bits [1:0] forced to 0 internally.
REQ-009 pc_i  input  32  current value of the PC register.
REQ-010 imem_ack_i  input  1  instruction memory returns data this cycle.
REQ-011 imem_req_o  output  1  fetch request; address is pc_i.
REQ-012 pc_write_o  output  1  one-cycle PC load strobe, driving the PC register's write and start enables.
REQ-013 pc_next_o  output  32  value to be loaded into the PC when pc_write_o is high.
REQ-014 inst_valid_o  output  1  returned instruction is to be latched into IF/ID.
REQ-015 flush_o  output  1  one-cycle pulse that squashes IF/ID.
REQ-016 err_o  output  1  sticky fetch-timeout flag.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, HOLD and REDIRECT; all outputs are decoded from state and current inputs in the same cycle.
REQ-018 IDLE: imem_req_o=0 and pc_write_o=0; start_i=1 SHALL move to FETCH on the next edge; err_o=1 SHALL block leaving IDLE.
REQ-019 FETCH: imem_req_o SHALL be 1.
REQ-020 FETCH with ack, no branch, no stall: inst_valid_o=1 and pc_write_o=1 with pc_next_o=pc_i+4; stay in FETCH, or go to IDLE if start_i=0.
REQ-021 FETCH with ack and stall_i=1, no branch: inst_valid_o=1, pc_write_o=0, next state HOLD.
REQ-022 FETCH with ack and branch_i=1: inst_valid_o=0, flush_o=1, pc_write_o=1 with pc_next_o=target; stay in FETCH.
REQ-023 FETCH with branch_i=1 and no ack: latch target, flush_o=1, next state REDIRECT.
REQ-024 REDIRECT: imem_req_o=1; on ack, discard the data (inst_valid_o=0) and set pc_write_o=1 with pc_next_o=latched target, then go to FETCH; a new branch_i here SHALL overwrite the latched target.
REQ-025 HOLD: imem_req_o=0 and pc_write_o=0 while stall_i=1.
REQ-026 HOLD, stall_i falls: pc_write_o=1 with pc_next_o=pc_i+4; next state FETCH, or IDLE if start_i=0.
REQ-027 HOLD with branch_i=1: pc_write_o=1 with target, flush_o=1, next state FETCH.
REQ-028 Priority SHALL be branch_i > stall_i > sequential.
REQ-029 start_i SHALL be sampled only in IDLE, at an ack in FETCH, and at stall release in HOLD; an outstanding request always completes.
REQ-030 pc_i+4 SHALL wrap modulo 2^32, so 32'hFFFF_FFFC is followed by 32'h0.
REQ-031 Timeout: a counter SHALL increment each FETCH or REDIRECT cycle without ack and clear on ack; when it reaches ACK_TIMEOUT, set err_o=1, drop imem_req_o, and go to IDLE on the next edge.
REQ-032 pc_next_o SHALL equal pc_i whenever pc_write_o=0, and RESET_PC in IDLE.

Reset
REQ-033 While rst_i=1 at an edge: state=IDLE, imem_req_o=0, pc_write_o=0, inst_valid_o=0, flush_o=0, err_o=0, pc_next_o=RESET_PC, latched target=0, counter=0.
REQ-034 Reset asserted mid-fetch SHALL abandon the request with no discard bookkeeping.
REQ-035 err_o SHALL clear only on reset.

Structure
REQ-036 Package pc_seq_pkg SHALL hold the state enumeration, PC_INC=4, and the default RESET_PC.
REQ-037 The timeout counter SHALL be a sub-module, ack_watchdog (inputs: count enable, clear, limit; output: expired).

Verification
REQ-038 Reset, start_i=1, ack every cycle, pc_i tracking pc_next_o: PC runs 0,4,8,C; inst_valid_o=1 each cycle.
REQ-039 Ack at pc_i=8 with stall_i=1 for 3 cycles: pc_write_o=0 for 3 cycles, then pc_next_o=C.
REQ-040 branch_i with target 32'h40 two cycles before ack: flush_o one pulse, returned data discarded, pc_next_o=40 at ack.
REQ-041 branch_i and stall_i together at ack, target 32'h103: pc_next_o=32'h100, flush_o=1, no HOLD.
REQ-042 ack withheld 15 cycles, ACK_TIMEOUT=15: err_o=1, imem_req_o=0, state IDLE; start_i has no effect until rst_i.
REQ-043 pc_i=32'hFFFF_FFFC with ack: pc_next_o=0; rst_i asserted during the next fetch: all outputs at their reset values next cycle.
